// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory: access-size encodings, clear FSM
// states and the alignment / lane-mask helpers used by the store and load paths.
package data_memory_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clearState_e;

  // Reserved size is never aligned, so it falls out as a misalignment fault.
  function automatic logic isAligned(input logic [1:0] size, input logic [1:0] offset);
    logic ok;
    ok = 1'b0;
    case (size)
      SIZE_WORD: ok = (offset == 2'b00);
      SIZE_HALF: ok = ~offset[0];
      SIZE_BYTE: ok = 1'b1;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] laneMask(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      SIZE_WORD: mask = 4'b1111;
      SIZE_HALF: mask = 4'b0011 << offset;
      SIZE_BYTE: mask = 4'b0001 << offset;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// MEM-stage request/response bundle between the pipeline (master) and the
// data memory (slave).
interface data_memory_if;

  logic        memwrite;
  logic        memread;
  logic [1:0]  memsize;
  logic        mem_unsigned;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busy;
  logic        misalign;
  logic        fault_sticky;

  modport master (
    output memwrite, memread, memsize, mem_unsigned, address, writedata,
    input  readdata, busy, misalign, fault_sticky
  );

  modport slave (
    input  memwrite, memread, memsize, mem_unsigned, address, writedata,
    output readdata, busy, misalign, fault_sticky
  );

endinterface

// File: rtl/load_extend.sv
// Pure combinational load lane selection and sign/zero extension; shared with
// the MEM stage so both agree on byte ordering (little-endian).
module load_extend
  import data_memory_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = word_i[7:0];
    case (offset_i)
      2'd0: byteSel = word_i[7:0];
      2'd1: byteSel = word_i[15:8];
      2'd2: byteSel = word_i[23:16];
      2'd3: byteSel = word_i[31:24];
      default: byteSel = word_i[7:0];
    endcase
    halfSel = offset_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = '0;
    case (size_i)
      SIZE_WORD: data_o = word_i;
      SIZE_HALF: data_o = unsigned_i ? {16'h0000, halfSel} : {{16{halfSel[15]}}, halfSel};
      SIZE_BYTE: data_o = unsigned_i ? {24'h000000, byteSel} : {{24{byteSel[7]}}, byteSel};
      default:   data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable data memory with combinational loads, one-cycle stores and
// a post-reset clear sweep that zeroes every word before accesses are serviced.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH_WORDS = 64
) (
  input  logic          clk,
  input  logic          reset,
  data_memory_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W:0] LAST_PTR = (IDX_W + 1)'(DEPTH_WORDS - 1);
  localparam logic [IDX_W:0] PTR_ONE  = (IDX_W + 1)'(1);

  logic [31:0] mem_q [DEPTH_WORDS];

  clearState_e     state_q, state_d;
  logic [IDX_W:0]  clearPtr_q, clearPtr_d;
  logic            faultSticky_q, faultSticky_d;

  logic [IDX_W-1:0] wordIdx;
  logic             outOfRange;
  logic             access;
  logic             misalign;
  logic             busy;
  logic             storeFire;
  logic             loadFire;

  logic             wrEn;
  logic [IDX_W-1:0] wrIdx;
  logic [31:0]      wrData;
  logic [3:0]       wrMask;

  logic [31:0]      rdWord;
  logic [31:0]      loadData;

  assign wordIdx    = bus.address[IDX_W+1:2];
  assign outOfRange = |bus.address[31:IDX_W+2];
  assign access     = bus.memread | bus.memwrite;
  assign misalign   = access & (~isAligned(bus.memsize, bus.address[1:0]) | outOfRange);

  // Reset is folded into busy so nothing is serviced before the first edge lands us in CLEAR.
  assign busy      = (state_q == ST_CLEAR) | reset;
  assign storeFire = bus.memwrite & ~busy & ~misalign;
  assign loadFire  = bus.memread  & ~busy & ~misalign;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_CLEAR;
      clearPtr_q    <= '0;
      faultSticky_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clearPtr_q    <= clearPtr_d;
      faultSticky_q <= faultSticky_d;
    end
  end

  // Leave CLEAR on the same edge that zeroes the last word, so busy lasts exactly DEPTH_WORDS cycles.
  always_comb begin
    state_d       = state_q;
    clearPtr_d    = clearPtr_q;
    faultSticky_d = faultSticky_q | (misalign & ~busy);
    case (state_q)
      ST_CLEAR: begin
        clearPtr_d = clearPtr_q + PTR_ONE;
        if (clearPtr_q == LAST_PTR) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        clearPtr_d = clearPtr_q;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Single write port shared by the clear sweep and pipeline stores.
  always_comb begin
    wrEn   = 1'b0;
    wrIdx  = wordIdx;
    wrData = bus.writedata;
    wrMask = laneMask(bus.memsize, bus.address[1:0]);
    if ((state_q == ST_CLEAR) && !reset) begin
      wrEn   = 1'b1;
      wrIdx  = clearPtr_q[IDX_W-1:0];
      wrData = '0;
      wrMask = 4'b1111;
    end else if (storeFire) begin
      wrEn = 1'b1;
      case (bus.memsize)
        SIZE_HALF: wrData = {bus.writedata[15:0], bus.writedata[15:0]};
        SIZE_BYTE: wrData = {4{bus.writedata[7:0]}};
        default:   wrData = bus.writedata;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int b = 0; b < 4; b++) begin
        if (wrMask[b]) begin
          mem_q[wrIdx][8*b +: 8] <= wrData[8*b +: 8];
        end
      end
    end
  end

  assign rdWord = mem_q[wordIdx];

  load_extend u_load_extend (
    .word_i     (rdWord),
    .offset_i   (bus.address[1:0]),
    .size_i     (bus.memsize),
    .unsigned_i (bus.mem_unsigned),
    .data_o     (loadData)
  );

  assign bus.readdata     = loadFire ? loadData : 32'h0000_0000;
  assign bus.busy         = busy;
  assign bus.misalign     = misalign;
  assign bus.fault_sticky = faultSticky_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus random accesses
// compared against a byte-array reference model of the memory.
module tb_data_memory;

  logic clk = 1'b0;
  logic reset;

  data_memory_if bus ();

  data_memory #(.DEPTH_WORDS(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] refMem [256];
  int         busyLeft;
  logic       refSticky;
  int         vectors;
  int         miscompares;

  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] sz,
                               input logic uns, input logic [31:0] a, input logic [31:0] wd,
                               input logic rst);
    bus.memread      = rd;
    bus.memwrite     = wr;
    bus.memsize      = sz;
    bus.mem_unsigned = uns;
    bus.address      = a;
    bus.writedata    = wd;
    reset            = rst;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic refBad(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b00 && a[1:0] != 2'b00) ||
           (sz == 2'b01 && a[0]) || (a >= 32'd256);
  endfunction

  function automatic logic [31:0] refLoad(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    int base;
    logic [15:0] h;
    logic [7:0]  b;
    base = int'(a);
    case (sz)
      2'b00: return {refMem[base+3], refMem[base+2], refMem[base+1], refMem[base]};
      2'b01: begin
        h = {refMem[base+1], refMem[base]};
        return uns ? {16'h0000, h} : {{16{h[15]}}, h};
      end
      2'b10: begin
        b = refMem[base];
        return uns ? {24'h000000, b} : {{24{b[7]}}, b};
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic step(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a, input logic [31:0] wd,
                      input logic rst, output logic [31:0] rdObs);
    logic        expMis;
    logic        expBusy;
    logic [31:0] expRd;
    @(negedge clk);
    applyStimulus(rd, wr, sz, uns, a, wd, rst);
    #1;
    expMis  = (rd | wr) & refBad(sz, a);
    expBusy = rst || (busyLeft > 0);
    expRd   = (rd && !expBusy && !expMis) ? refLoad(sz, uns, a) : 32'h0;
    checkOutput({tag, ".readdata"}, bus.readdata, expRd);
    checkOutput({tag, ".busy"}, {31'h0, bus.busy}, {31'h0, expBusy});
    checkOutput({tag, ".misalign"}, {31'h0, bus.misalign}, {31'h0, expMis});
    checkOutput({tag, ".sticky"}, {31'h0, bus.fault_sticky}, {31'h0, refSticky});
    rdObs = bus.readdata;
    @(posedge clk);
    if (rst) begin
      busyLeft  = 64;
      refSticky = 1'b0;
      for (int i = 0; i < 256; i++) refMem[i] = 8'h00;
    end else if (busyLeft > 0) begin
      busyLeft--;
    end else begin
      if (expMis) refSticky = 1'b1;
      if (wr && !expMis) begin
        case (sz)
          2'b00: for (int k = 0; k < 4; k++) refMem[int'(a) + k] = wd[8*k +: 8];
          2'b01: for (int k = 0; k < 2; k++) refMem[int'(a) + k] = wd[8*k +: 8];
          default: refMem[int'(a)] = wd[7:0];
        endcase
      end
    end
  endtask

  initial begin
    logic [31:0] obs;
    logic [1:0]  sz;
    logic [31:0] a;
    vectors     = 0;
    miscompares = 0;
    refSticky   = 1'b0;
    busyLeft    = 64;
    for (int i = 0; i < 256; i++) refMem[i] = 8'h00;

    // Reset state
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset.busy", {31'h0, bus.busy}, 32'h1);
    checkOutput("reset.readdata", bus.readdata, 32'h0);
    checkOutput("reset.sticky", {31'h0, bus.fault_sticky}, 32'h0);

    // Clear sweep: 64 busy cycles, then serviced
    for (int n = 0; n < 64; n++) step("clear", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, obs);
    step("clearDone", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, obs);
    checkOutput("clearDone.lit", obs, 32'h0);

    // Load extension
    step("sw", 1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h8001FF7F, 1'b0, obs);
    step("lb", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, obs);
    checkOutput("lb.lit", obs, 32'h0000007F);
    step("lbu", 1'b1, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 1'b0, obs);
    checkOutput("lbu.lit", obs, 32'h0000007F);
    step("lh", 1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, obs);
    checkOutput("lh.lit", obs, 32'hFFFF8001);
    step("lhu", 1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, obs);
    checkOutput("lhu.lit", obs, 32'h00008001);
    step("lw", 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, obs);
    checkOutput("lw.lit", obs, 32'h8001FF7F);

    // Byte store merges into existing word
    step("sw2", 1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h11223344, 1'b0, obs);
    step("sb", 1'b0, 1'b1, 2'b10, 1'b0, 32'h13, 32'h000000AA, 1'b0, obs);
    step("lwMerge", 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, obs);
    checkOutput("lwMerge.lit", obs, 32'hAA223344);

    // Read-during-write returns old data
    step("sw5", 1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h5, 1'b0, obs);
    step("rdw", 1'b1, 1'b1, 2'b00, 1'b0, 32'h20, 32'hDEADBEEF, 1'b0, obs);
    checkOutput("rdw.old", obs, 32'h5);
    step("rdwNext", 1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b0, obs);
    checkOutput("rdwNext.new", obs, 32'hDEADBEEF);

    // Faults: misaligned store, misaligned/out-of-range load
    step("swMis", 1'b0, 1'b1, 2'b00, 1'b0, 32'h2, 32'hFFFFFFFF, 1'b0, obs);
    step("lhOor", 1'b1, 1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 1'b0, obs);
    checkOutput("lhOor.lit", obs, 32'h0);
    checkOutput("sticky.lit", {31'h0, bus.fault_sticky}, 32'h1);
    step("lw0", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, obs);
    checkOutput("lw0.unchanged", obs, 32'h0);
    step("rsvd", 1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b0, obs);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 300));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b00) a = a & ~32'h3;
        if (sz == 2'b01) a = a & ~32'h1;
      end
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz,
           1'($urandom_range(0, 1)), a, $urandom, 1'b0, obs);
    end

    // Reset mid-clear restarts the sweep; busy accesses are dropped
    step("rst2", 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, obs);
    for (int n = 0; n < 30; n++) step("busyDrop", 1'b1, 1'b1, 2'b00, 1'b0, 32'h2, 32'h12345678, 1'b0, obs);
    step("rst3", 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, obs);
    for (int n = 0; n < 64; n++) step("reclear", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, obs);
    checkOutput("reclear.sticky", {31'h0, bus.fault_sticky}, 32'h0);
    for (int w = 0; w < 64; w++) begin
      step("zero", 1'b1, 1'b0, 2'b00, 1'b0, 32'(w * 4), 32'h0, 1'b0, obs);
      checkOutput("zero.lit", obs, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
